// File: rtl/fifo_v3.sv
// Synchronous FIFO with show-ahead output, occupancy count and threshold flags.
// Define FIFO_V3_ERR_FLAGS_EN to add sticky overflow_o / underflow_o outputs.
module fifo_v3 #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
   parameter int unsigned ALM_EMPTY_TH = 1,
   localparam int unsigned CntW        = $clog2(DEPTH + 1),
   localparam int unsigned PtrW        = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             testmode_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             push_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             alm_full_o,
   output logic             alm_empty_o,
`ifdef FIFO_V3_ERR_FLAGS_EN
   output logic             overflow_o,
   output logic             underflow_o,
`endif
   output logic [CntW-1:0]  usage_o
);

   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_v3: WIDTH must be >= 1");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_v3: DEPTH must be >= 2");
   end
   if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH) begin : g_bad_af
      $error("fifo_v3: ALM_FULL_TH out of range");
   end
   if (ALM_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_v3: ALM_EMPTY_TH out of range");
   end

   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
   localparam logic [CntW-1:0] AlmFullCnt = CntW'(ALM_FULL_TH);
   localparam logic [CntW-1:0] AlmEmptyCnt = CntW'(ALM_EMPTY_TH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             full, empty;
   logic             push_ok, pop_ok;

   // DFT input intentionally has no functional effect.
   logic unused_testmode;
   assign unused_testmode = testmode_i;

   assign full  = (cnt_q == DepthCnt);
   assign empty = (cnt_q == '0);

   // A push at full is accepted only when a pop frees a slot on the same edge.
   assign pop_ok  = pop_i && !empty && !flush_i;
   assign push_ok = push_i && (!full || pop_i) && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is left unreset; empty gating on data_o hides stale words.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

`ifdef FIFO_V3_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   // A pop on empty paired with a push is not an underflow: the push is served.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_i && full && !pop_i) begin
            overflow_q <= 1'b1;
         end
         if (pop_i && empty && !push_i) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
`endif

   assign data_o      = empty ? '0 : mem_q[rd_ptr_q];
   assign full_o      = full;
   assign empty_o     = empty;
   assign usage_o     = cnt_q;
   assign alm_full_o  = (cnt_q >= AlmFullCnt);
   assign alm_empty_o = (cnt_q <= AlmEmptyCnt);

endmodule

// File: tb/tb_fifo_v3.sv
// Directed bench for fifo_v3: an 8-deep instance with custom thresholds and a
// 5-deep instance (non-power-of-two wrap) driven by the same stimulus.
module tb_fifo_v3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush, push, pop;
   logic [7:0] din;

   logic [7:0] a_data, b_data;
   logic       a_full, a_empty, a_af, a_ae;
   logic       b_full, b_empty, b_af, b_ae;
   logic [3:0] a_usage;
   logic [2:0] b_usage;
`ifdef FIFO_V3_ERR_FLAGS_EN
   logic       a_ovf, a_unf, b_ovf, b_unf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fifo_v3 #(
      .WIDTH       (8),
      .DEPTH       (8),
      .ALM_FULL_TH (6),
      .ALM_EMPTY_TH(2)
   ) u_dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .testmode_i (1'b0),
      .flush_i    (flush),
      .data_i     (din),
      .push_i     (push),
      .pop_i      (pop),
      .data_o     (a_data),
      .full_o     (a_full),
      .empty_o    (a_empty),
      .alm_full_o (a_af),
      .alm_empty_o(a_ae),
`ifdef FIFO_V3_ERR_FLAGS_EN
      .overflow_o (a_ovf),
      .underflow_o(a_unf),
`endif
      .usage_o    (a_usage)
   );

   fifo_v3 #(
      .WIDTH(8),
      .DEPTH(5)
   ) u_dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .testmode_i (1'b1),
      .flush_i    (flush),
      .data_i     (din),
      .push_i     (push),
      .pop_i      (pop),
      .data_o     (b_data),
      .full_o     (b_full),
      .empty_o    (b_empty),
      .alm_full_o (b_af),
      .alm_empty_o(b_ae),
`ifdef FIFO_V3_ERR_FLAGS_EN
      .overflow_o (b_ovf),
      .underflow_o(b_unf),
`endif
      .usage_o    (b_usage)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic pu, input logic po, input logic fl, input logic [7:0] d);
      push  = pu;
      pop   = po;
      flush = fl;
      din   = d;
      @(posedge clk);
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
      din   = 8'h00;
   endtask

   initial begin
      logic [7:0] a_exp [8];
      logic [7:0] b_exp [5];
      a_exp = '{8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'hA0, 8'hA1, 8'hA2};
      b_exp = '{8'h44, 8'h45, 8'hA0, 8'hA1, 8'hA2};

      rst_n = 1'b1;
      flush = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      din   = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      check("rst_usage", a_usage, 0);
      check("rst_empty", a_empty, 1);
      check("rst_full", a_full, 0);
      check("rst_alm_empty", a_ae, 1);
      check("rst_alm_full", a_af, 0);
      check("rst_data", a_data, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic ordering and show-ahead latency.
      op(1, 0, 0, 8'h11);
      check("p1_empty", a_empty, 0);
      check("p1_data", a_data, 8'h11);
      check("p1_alm_empty", a_ae, 1);
      op(1, 0, 0, 8'h22);
      op(1, 0, 0, 8'h33);
      check("p3_usage_a", a_usage, 3);
      check("p3_usage_b", b_usage, 3);
      check("p3_alm_empty", a_ae, 0);
      check("p3_data", a_data, 8'h11);
      op(0, 1, 0, 8'h00);
      check("pop1_data", a_data, 8'h22);
      op(0, 1, 0, 8'h00);
      check("pop2_data", b_data, 8'h33);
      op(0, 1, 0, 8'h00);
      check("pop3_empty", a_empty, 1);
      check("pop3_data", a_data, 0);

      // Pop on empty with a simultaneous push: only the push is taken.
      op(1, 1, 0, 8'hAA);
      check("pe_usage", a_usage, 1);
      check("pe_data", a_data, 8'hAA);
      check("pe_usage_b", b_usage, 1);
`ifdef FIFO_V3_ERR_FLAGS_EN
      check("pe_underflow", a_unf, 0);
      check("pe_overflow", a_ovf, 0);
`endif
      op(0, 1, 0, 8'h00);
      check("pe_drain", a_empty, 1);

      // Fill both; the 5-deep one saturates and drops the extra pushes.
      for (int k = 1; k <= 8; k++) begin
         op(1, 0, 0, 8'(8'h40 + k));
         check($sformatf("fill%0d_usage_a", k), a_usage, k);
         check($sformatf("fill%0d_ae", k), a_ae, (k <= 2));
         check($sformatf("fill%0d_af", k), a_af, (k >= 6));
         check($sformatf("fill%0d_usage_b", k), b_usage, (k < 5) ? k : 5);
         check($sformatf("fill%0d_full_b", k), b_full, (k >= 5));
`ifdef FIFO_V3_ERR_FLAGS_EN
         check($sformatf("fill%0d_ovf_b", k), b_ovf, (k >= 6));
`endif
      end
      check("full_a", a_full, 1);
      op(1, 0, 0, 8'h99);
      check("drop_usage_a", a_usage, 8);
      check("drop_data_a", a_data, 8'h41);
`ifdef FIFO_V3_ERR_FLAGS_EN
      check("drop_ovf_a", a_ovf, 1);
`endif

      // Push and pop together at full.
      for (int j = 0; j < 3; j++) begin
         op(1, 1, 0, 8'(8'hA0 + j));
         check($sformatf("pp%0d_usage_a", j), a_usage, 8);
         check($sformatf("pp%0d_data_a", j), a_data, 8'(8'h42 + j));
         check($sformatf("pp%0d_usage_b", j), b_usage, 5);
         check($sformatf("pp%0d_data_b", j), b_data, 8'(8'h42 + j));
      end

      // Drain across the pointer wrap.
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d_a", i), a_data, a_exp[i]);
         if (i < 5) check($sformatf("drain%0d_b", i), b_data, b_exp[i]);
         op(0, 1, 0, 8'h00);
      end
      check("drain_empty_a", a_empty, 1);
      check("drain_empty_b", b_empty, 1);
      check("drain_data_a", a_data, 0);
      check("drain_data_b", b_data, 0);
`ifdef FIFO_V3_ERR_FLAGS_EN
      check("drain_unf_b", b_unf, 1);
      check("drain_unf_a", a_unf, 0);
`endif

      // Flush wins over push and pop.
      for (int k = 0; k < 4; k++) op(1, 0, 0, 8'(8'h60 + k));
      check("pre_flush_usage", a_usage, 4);
      op(1, 1, 1, 8'hEE);
      check("flush_usage_a", a_usage, 0);
      check("flush_usage_b", b_usage, 0);
      check("flush_empty", a_empty, 1);
      check("flush_ae", a_ae, 1);
      check("flush_data", a_data, 0);
`ifdef FIFO_V3_ERR_FLAGS_EN
      check("flush_ovf_b", b_ovf, 0);
      check("flush_unf_b", b_unf, 0);
      check("flush_ovf_a", a_ovf, 0);
`endif
      op(1, 0, 0, 8'h77);
      check("post_flush_data", b_data, 8'h77);
      check("post_flush_usage", b_usage, 1);
      op(0, 0, 1, 8'h00);

      // Asynchronous reset between edges with data in flight.
      for (int k = 0; k < 3; k++) op(1, 0, 0, 8'(8'h30 + k));
      check("pre_rst_usage", a_usage, 3);
      #3 rst_n = 1'b0;
      #1;
      check("arst_usage_a", a_usage, 0);
      check("arst_usage_b", b_usage, 0);
      check("arst_empty", a_empty, 1);
      check("arst_full_b", b_full, 0);
      check("arst_ae", a_ae, 1);
      check("arst_af", a_af, 0);
      check("arst_data", a_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      op(1, 0, 0, 8'h5A);
      check("post_rst_data", a_data, 8'h5A);
      check("post_rst_usage", a_usage, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
